lib_arb_input_queue: RTL and testbench

Per-requester input buffering stage placed directly upstream of the round-robin programmable priority encoder. Each of N sources writes words into its own FIFO. The block presents a request vector built from non-empty FIFOs to the arbiter. It consumes the one-hot grant the arbiter returns, pops the granted FIFO and registers the winning word toward the shared output. Output back-pressure masks all requests, so the arbiter's priority pointer never advances on a cycle that cannot transfer.

---
 rtl/lib_arb_pkg.sv | 21 ++
 rtl/lib_fifo_sync.sv | 72 +++++++
 rtl/lib_arb_input_queue.sv | 107 ++++++++++
 tb/tb_lib_arb_input_queue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lib_arb_pkg.sv
// rtl/lib_arb_pkg.sv - shared defaults and helpers for the arbiter input queue
package lib_arb_pkg;

    localparam int N_DEF     = 4;
    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 4;

    // Widest request vector the one-hot helper accepts
    localparam int MAX_N     = 64;

    // True when exactly one bit of vec is set
    function automatic logic onehot_chk(input logic [MAX_N-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

    // Occupancy counter width: must hold the value DEPTH itself
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lib_fifo_sync.sv
// rtl/lib_fifo_sync.sv - single-clock FIFO with combinational head word
module lib_fifo_sync
    import lib_arb_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Overflow and underflow are blocked here so the storage can never corrupt
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lib_arb_input_queue.sv
// rtl/lib_arb_input_queue.sv - per-requester FIFOs feeding a round-robin arbiter
module lib_arb_input_queue
    import lib_arb_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:N-1][WIDTH-1:0]  i_data_in,
    input  logic [0:N-1]             i_data_val,
    output logic [0:N-1]             o_en,
    output logic [0:N-1]             o_request,
    input  logic [0:N-1]             i_grant,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_data_val,
    input  logic                     i_en,
    output logic                     o_grant_err
);

    localparam int CW = count_width(DEPTH);

    logic [N-1:0]       w_push;
    logic [N-1:0]       w_pop;
    logic [N-1:0]       w_full;
    logic [N-1:0]       w_empty;
    logic [N-1:0]       w_q;
    logic [WIDTH-1:0]   w_head  [N];
    logic [CW-1:0]      w_count [N];
    logic [WIDTH-1:0]   w_win;
    logic               w_stall;
    logic               w_q_onehot;
    logic               w_q_multi;
    logic               w_any_pop;

    logic [WIDTH-1:0]   r_data;
    logic               r_data_val;
    logic               r_grant_err;

    // A held output word that downstream refuses blocks every request, so the
    // arbiter pointer only moves on cycles that actually transfer a word
    assign w_stall = r_data_val & ~i_en;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_src
            assign o_en[gi]      = ~w_full[gi];
            assign w_push[gi]    = i_data_val[gi] & ~w_full[gi];
            assign o_request[gi] = (w_count[gi] != '0) & ~w_stall;
            assign w_q[gi]       = i_grant[gi] & o_request[gi];
            assign w_pop[gi]     = w_q_onehot & w_q[gi] & ~w_empty[gi];

            lib_fifo_sync #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset   (reset),
                .i_push  (w_push[gi]),
                .i_pop   (w_pop[gi]),
                .i_wdata (i_data_in[gi]),
                .o_rdata (w_head[gi]),
                .o_count (w_count[gi]),
                .o_full  (w_full[gi]),
                .o_empty (w_empty[gi])
            );
        end
    endgenerate

    // Only a single-bit qualified grant may pop; multi-hot is reported instead
    assign w_q_onehot = onehot_chk(MAX_N'(w_q));
    assign w_q_multi  = (w_q != '0) & ~w_q_onehot;
    assign w_any_pop  = (w_pop != '0);

    // Select the head word of the granted source (at most one pop bit is set)
    always_comb begin
        w_win = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pop[i]) begin
                w_win = w_win | w_head[i];
            end
        end
    end

    // Single-stage output register; reloads in the same cycle it drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_data_val  <= 1'b0;
            r_grant_err <= 1'b0;
        end else begin
            r_grant_err <= w_q_multi;
            if (w_any_pop) begin
                r_data     <= w_win;
                r_data_val <= 1'b1;
            end else if (i_en) begin
                r_data_val <= 1'b0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_data_val  = r_data_val;
    assign o_grant_err = r_grant_err;

endmodule

// File: tb/tb_lib_arb_input_queue.sv
// tb/tb_lib_arb_input_queue.sv - directed bench for the arbiter input queue
module tb_lib_arb_input_queue;

    logic             clk = 1'b0;
    logic             reset;
    logic [0:3][31:0] data_in;
    logic [0:3]       data_val;
    logic [0:3]       o_en;
    logic [0:3]       o_request;
    logic [0:3]       i_grant;
    logic [31:0]      o_data;
    logic             o_data_val;
    logic             i_en;
    logic             o_grant_err;

    logic             use_force;
    logic [0:3]       grant_force;
    logic [0:3]       rr_grant;
    int               rr_ptr;
    int               rr_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lib_arb_input_queue #(.N(4), .WIDTH(32), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_data_in   (data_in),
        .i_data_val  (data_val),
        .o_en        (o_en),
        .o_request   (o_request),
        .i_grant     (i_grant),
        .o_data      (o_data),
        .o_data_val  (o_data_val),
        .i_en        (i_en),
        .o_grant_err (o_grant_err)
    );

    // Reference round-robin arbiter closing the loop
    always_comb begin
        rr_grant = '0;
        rr_idx   = 0;
        for (int k = 0; k < 4; k++) begin
            if (rr_grant == '0 && o_request[(rr_ptr + k) % 4]) begin
                rr_grant[(rr_ptr + k) % 4] = 1'b1;
                rr_idx = (rr_ptr + k) % 4;
            end
        end
    end

    assign i_grant = use_force ? grant_force : rr_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 0;
        end else if (!use_force && rr_grant != '0) begin
            rr_ptr <= (rr_idx + 1) % 4;
        end
    end

    typedef struct {
        logic [0:3]       val;
        logic [0:3][31:0] din;
        logic             en;
        logic             force_g;
        logic [0:3]       gnt;
        logic [0:3]       x_en;
        logic [0:3]       x_req;
        logic             x_val;
        logic [31:0]      x_data;
        logic             x_err;
    } vec_t;

    vec_t tv [10];

    function automatic vec_t mk(input logic [0:3] val, input logic [31:0] d1,
                                input logic [31:0] d2, input logic en,
                                input logic fg, input logic [0:3] g,
                                input logic [0:3] xreq, input logic xval,
                                input logic [31:0] xdata, input logic xerr);
        vec_t v;
        v.val     = val;
        v.din[0]  = 32'h0;
        v.din[1]  = d1;
        v.din[2]  = d2;
        v.din[3]  = 32'h0;
        v.en      = en;
        v.force_g = fg;
        v.gnt     = g;
        v.x_en    = 4'b1111;
        v.x_req   = xreq;
        v.x_val   = xval;
        v.x_data  = xdata;
        v.x_err   = xerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        data_val    = '0;
        data_in     = '0;
        use_force   = 1'b1;
        grant_force = '0;
        i_en        = 1'b1;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        use_force = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset then idle for 10 cycles
        chk("reset_data", o_data, 32'h0);
        chk("reset_err", o_grant_err, 1'b0);
        for (int c = 0; c < 10; c++) begin
            chk("idle_en", o_en, 4'b1111);
            chk("idle_req", o_request, 4'b0000);
            chk("idle_val", o_data_val, 1'b0);
            tick();
        end

        // Table: latency, grant error, stall, reload
        tv[0] = mk(4'b0010, 32'h0,  32'hA5, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,  1'b0);
        tv[1] = mk(4'b0000, 32'h0,  32'h0,  1'b1, 1'b0, 4'b0000, 4'b0010, 1'b1, 32'hA5, 1'b0);
        tv[2] = mk(4'b0000, 32'h0,  32'h0,  1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'hA5, 1'b0);
        tv[3] = mk(4'b0110, 32'h11, 32'h22, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'hA5, 1'b0);
        tv[4] = mk(4'b0000, 32'h0,  32'h0,  1'b1, 1'b1, 4'b0110, 4'b0110, 1'b0, 32'hA5, 1'b1);
        tv[5] = mk(4'b0000, 32'h0,  32'h0,  1'b1, 1'b1, 4'b0000, 4'b0110, 1'b0, 32'hA5, 1'b0);
        tv[6] = mk(4'b0000, 32'h0,  32'h0,  1'b1, 1'b0, 4'b0000, 4'b0110, 1'b1, 32'h11, 1'b0);
        tv[7] = mk(4'b0000, 32'h0,  32'h0,  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h11, 1'b0);
        tv[8] = mk(4'b0000, 32'h0,  32'h0,  1'b1, 1'b0, 4'b0000, 4'b0010, 1'b1, 32'h22, 1'b0);
        tv[9] = mk(4'b0000, 32'h0,  32'h0,  1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h22, 1'b0);

        for (int i = 0; i < 10; i++) begin
            data_val    = tv[i].val;
            data_in     = tv[i].din;
            i_en        = tv[i].en;
            use_force   = tv[i].force_g;
            grant_force = tv[i].gnt;
            #1;
            chk($sformatf("tv%0d_en", i), o_en, tv[i].x_en);
            chk($sformatf("tv%0d_req", i), o_request, tv[i].x_req);
            tick();
            chk($sformatf("tv%0d_val", i), o_data_val, tv[i].x_val);
            chk($sformatf("tv%0d_data", i), o_data, tv[i].x_data);
            chk($sformatf("tv%0d_err", i), o_grant_err, tv[i].x_err);
        end

        // Fill source 0 with no grants, overflow strobe, then drain in order
        do_reset();
        i_en = 1'b0;
        for (int w = 0; w < 4; w++) begin
            chk("fill_en_open", o_en, 4'b1111);
            data_val   = 4'b1000;
            data_in[0] = 32'hC0 + w;
            tick();
        end
        chk("fill_en_full", o_en, 4'b0111);
        data_in[0] = 32'hC4;
        tick();
        data_val = '0;
        chk("fill_drop_en", o_en, 4'b0111);
        chk("fill_drop_req", o_request, 4'b1000);
        use_force = 1'b0;
        i_en      = 1'b1;
        for (int w = 0; w < 4; w++) begin
            tick();
            chk("drain_val", o_data_val, 1'b1);
            chk("drain_data", o_data, 32'hC0 + w);
            chk("drain_en", o_en, 4'b1111);
        end
        tick();
        chk("drain_done_val", o_data_val, 1'b0);

        // Two words per source, loop closed: full-throughput round robin
        do_reset();
        for (int w = 0; w < 2; w++) begin
            data_val = 4'b1111;
            for (int s = 0; s < 4; s++) data_in[s] = 32'h100 * s + w;
            tick();
        end
        data_val  = '0;
        use_force = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_val", o_data_val, 1'b1);
            chk("rr_data", o_data, 32'h100 * (k % 4) + (k / 4));
        end
        tick();
        chk("rr_done_val", o_data_val, 1'b0);

        // Output stall holds data and masks requests
        do_reset();
        i_en = 1'b0;
        for (int w = 0; w < 2; w++) begin
            data_val   = 4'b0001;
            data_in[3] = 32'hD0 + w;
            tick();
        end
        data_val  = '0;
        use_force = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("stall_req", o_request, 4'b0000);
            chk("stall_val", o_data_val, 1'b1);
            chk("stall_data", o_data, 32'hD0);
            tick();
        end
        i_en = 1'b1;
        #1;
        chk("release_req", o_request, 4'b0001);
        tick();
        chk("release_val", o_data_val, 1'b1);
        chk("release_data", o_data, 32'hD1);

        // Asynchronous reset mid-burst with queued data and a held word
        i_en      = 1'b0;
        use_force = 1'b1;
        data_val  = 4'b1000;
        data_in[0] = 32'hE0;
        tick();
        tick();
        data_val = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("areset_data", o_data, 32'h0);
        chk("areset_val", o_data_val, 1'b0);
        chk("areset_en", o_en, 4'b1111);
        chk("areset_req", o_request, 4'b0000);
        chk("areset_err", o_grant_err, 1'b0);
        tick();
        reset     = 1'b0;
        i_en      = 1'b1;
        use_force = 1'b0;
        #1;
        chk("post_reset_req", o_request, 4'b0000);
        tick();
        chk("post_reset_val", o_data_val, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
